// File: rtl/ov7670_capture.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// ov7670_capture
//   Samples the OV7670 parallel bus in RGB565 two-bytes-per-pixel mode.
//   Assembles 16-bit pixels and produces a frame-buffer write port: a one-cycle
//   strobe with raster coordinates for every pixel inside the active window.
//   Also reports frame completion, a wrapping frame count and a sticky
//   odd-byte line error.
//
// Ports
//   clk        in   camera pixel clock, all logic on rising edge
//   reset      in   asynchronous active-high reset
//   captureEn  in   permits capture to start at the next frame boundary
//   vsync      in   camera vsync (high = vertical blanking)
//   href       in   camera href (high = valid byte on camData)
//   camData    in   camera data byte
//   writeEn    out  one-cycle pixel write strobe
//   outX       out  column of the pixel being written
//   outY       out  row of the pixel being written
//   pixelOut   out  RGB565 pixel
//   frameDone  out  one-cycle pulse at the end of each captured frame
//   frameCount out  captured frame count, wraps 255->0
//   lineErr    out  sticky: a line ended with an odd byte count
// ----------------------------------------------------------------------------
module ov7670_capture #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        captureEn,
    input  logic        vsync,
    input  logic        href,
    input  logic [7:0]  camData,
    output logic        writeEn,
    output logic [9:0]  outX,
    output logic [8:0]  outY,
    output logic [15:0] pixelOut,
    output logic        frameDone,
    output logic [7:0]  frameCount,
    output logic        lineErr
);

    localparam logic [9:0] H_LIM = 10'(H_ACTIVE);
    localparam logic [8:0] V_LIM = 9'(V_ACTIVE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SYNC,
        S_VBLANK,
        S_FRAME
    } state_t;

    state_t      r_state;

    // Input stage
    logic        r_vsync_q;
    logic        r_vsync_qq;
    logic        r_href_q;
    logic [7:0]  r_data_q;

    // Pixel assembly and raster counters
    logic        r_phase;
    logic [7:0]  r_hi_byte;
    logic [9:0]  r_x;
    logic [8:0]  r_y;
    logic        r_line_has_pix;

    // Registered outputs
    logic        r_write_en;
    logic [9:0]  r_out_x;
    logic [8:0]  r_out_y;
    logic [15:0] r_pixel;
    logic        r_frame_done;
    logic [7:0]  r_frame_count;
    logic        r_line_err;

    logic        w_vsync_rise;
    logic        w_vsync_fall;
    logic        w_byte;
    logic        w_pix;
    logic        w_hi;
    logic        w_line_end;
    logic        w_in_window;

    assign w_vsync_rise = r_vsync_q & ~r_vsync_qq;
    assign w_vsync_fall = ~r_vsync_q & r_vsync_qq;

    // A byte is consumed only while capturing a frame.
    assign w_byte      = (r_state == S_FRAME) & r_href_q;
    assign w_pix       = w_byte & r_phase;
    assign w_hi        = w_byte & ~r_phase;
    // hrefQ is about to fall: the current byte is the last one of the line,
    // so the counter reset lands on the same edge as the final pixel.
    assign w_line_end  = w_byte & ~href;
    assign w_in_window = (r_x < H_LIM) && (r_y < V_LIM);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_vsync_q      <= 1'b0;
            r_vsync_qq     <= 1'b0;
            r_href_q       <= 1'b0;
            r_data_q       <= 8'd0;
            r_phase        <= 1'b0;
            r_hi_byte      <= 8'd0;
            r_x            <= 10'd0;
            r_y            <= 9'd0;
            r_line_has_pix <= 1'b0;
            r_write_en     <= 1'b0;
            r_out_x        <= 10'd0;
            r_out_y        <= 9'd0;
            r_pixel        <= 16'd0;
            r_frame_done   <= 1'b0;
            r_frame_count  <= 8'd0;
            r_line_err     <= 1'b0;
        end else begin
            r_vsync_q    <= vsync;
            r_vsync_qq   <= r_vsync_q;
            r_href_q     <= href;
            r_data_q     <= camData;
            r_write_en   <= 1'b0;
            r_frame_done <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (captureEn) r_state <= S_SYNC;
                end

                // Wait for a full blanking interval so a partial frame is never written.
                S_SYNC: begin
                    if (w_vsync_rise) r_state <= S_VBLANK;
                end

                S_VBLANK: begin
                    if (w_vsync_fall) begin
                        if (captureEn) begin
                            r_state        <= S_FRAME;
                            r_x            <= 10'd0;
                            r_y            <= 9'd0;
                            r_phase        <= 1'b0;
                            r_line_has_pix <= 1'b0;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end

                S_FRAME: begin
                    if (w_vsync_rise) begin
                        r_state       <= S_VBLANK;
                        r_frame_done  <= 1'b1;
                        r_frame_count <= r_frame_count + 8'd1;
                    end

                    if (w_pix) begin
                        r_phase        <= 1'b0;
                        r_line_has_pix <= 1'b1;
                        if (w_in_window) begin
                            r_write_en <= 1'b1;
                            r_out_x    <= r_x;
                            r_out_y    <= r_y;
                            r_pixel    <= {r_hi_byte, r_data_q};
                        end
                        if (r_x != 10'h3FF) r_x <= r_x + 10'd1;
                    end

                    if (w_hi) begin
                        r_hi_byte <= r_data_q;
                        r_phase   <= 1'b1;
                    end

                    // NOTE: non-blocking assignments with last-assignment-wins:
                    // the line-end updates below override the per-pixel ones
                    // above, while the write port already captured the old r_x/r_y.
                    if (w_line_end) begin
                        r_x            <= 10'd0;
                        r_phase        <= 1'b0;
                        r_line_has_pix <= 1'b0;
                        if ((r_line_has_pix || w_pix) && (r_y != 9'h1FF)) r_y <= r_y + 9'd1;
                        // A high byte stored on the last byte of a line has no partner.
                        if (w_hi) r_line_err <= 1'b1;
                    end
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign writeEn    = r_write_en;
    assign outX       = r_out_x;
    assign outY       = r_out_y;
    assign pixelOut   = r_pixel;
    assign frameDone  = r_frame_done;
    assign frameCount = r_frame_count;
    assign lineErr    = r_line_err;

endmodule

// File: doc/ov7670_capture.md
# ov7670_capture

Camera-side capture block that produces the frame buffer's write port. It samples the OV7670 parallel bus (vsync, href, 8-bit data) in RGB565 two-bytes-per-pixel mode and assembles 16-bit pixels. It generates raster coordinates and a one-cycle write strobe for each pixel inside the active window. It also reports frame completion, a wrapping frame count, and a sticky framing error.

## Interface
- H_ACTIVE, 640, pixels per line that are written; later pixels are clipped.
- V_ACTIVE, 480, lines per frame that are written; later lines are clipped.
- clk  in  1  camera pixel clock; all logic on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- captureEn  in  1  level; permits capture to start at the next frame boundary.
- vsync  in  1  camera vsync; high = vertical blanking.
- href  in  1  camera href; high = valid byte on camData.
- camData  in  8  camera data byte.
- writeEn  out  1  one-cycle pixel write strobe.
- outX  out  10  column of the pixel being written.
- outY  out  9  row of the pixel being written.
- pixelOut  out  16  RGB565 pixel, RRRRR_GGGGGG_BBBBB.
- frameDone  out  1  one-cycle pulse at the end of each captured frame.
- frameCount  out  8  number of captured frames; wraps 255->0.
- lineErr  out  1  sticky; a line ended with an odd byte count. Cleared only by reset.

## Operation
- **Input stage.** vsync, href and camData are registered once into vsyncQ, hrefQ and dataQ. vsyncQ is registered again into vsyncQQ for edge detection. vsync rise = vsyncQ & ~vsyncQQ; vsync fall = ~vsyncQ & vsyncQQ.
- **State machine.** States are IDLE, SYNC, VBLANK and FRAME.
  - IDLE -> SYNC when captureEn=1.
  - SYNC -> VBLANK on vsync rise. SYNC never captures, so a partial frame is never written.
  - VBLANK -> FRAME on vsync fall if captureEn=1; otherwise VBLANK -> IDLE.
  - FRAME -> VBLANK on vsync rise. This transition pulses frameDone and increments frameCount.
  - Deasserting captureEn during FRAME does not abort capture; the current frame completes.
- **Byte pairing.** Applies in FRAME only, with a phase bit that resets to 0.
  - Each cycle with hrefQ=1 and phase 0: store dataQ as the high byte, set phase to 1.
  - Each cycle with hrefQ=1 and phase 1: pixel = {hiByte, dataQ}, set phase to 0, issue a pixel.
- **Pixel issue.**
  - If xCnt<H_ACTIVE and yCnt<V_ACTIVE, the next cycle has writeEn=1, pixelOut=pixel, outX=xCnt, outY=yCnt.
  - If either limit is exceeded, writeEn stays 0 (clip).
  - xCnt increments on every issued pixel, clipped or not, and saturates at 1023.
- **Line end (hrefQ 1->0 in FRAME).**
  - xCnt -> 0 and phase -> 0.
  - yCnt increments (saturating at 511) only if at least one pixel was issued on that line.
  - If phase was 1 at line end, lineErr is set and the dangling byte is dropped.
- **Frame start.** Entering FRAME sets xCnt=0, yCnt=0, phase=0.
- **Reset values.** All outputs 0; internal counters 0; state IDLE; all pipeline registers 0. Reset in mid-frame abandons that frame; capture restarts via IDLE->SYNC.

## Timing
- Low byte on camData at edge k (href high) -> dataQ at edge k -> writeEn/pixelOut/outX/outY registered at edge k+1. The write is visible for the one cycle after edge k+1, so latency is 2 edges from pin to strobe.
- outX, outY and pixelOut hold their last values when writeEn=0.
- writeEn is never high on two consecutive cycles, because each pixel takes two bytes.
- Last byte of a line falls on edge k with href low at edge k+1. The final pixel's writeEn follows edge k+1, and the xCnt reset and yCnt increment are also registered at edge k+1. The two events do not conflict because the pixel coordinates are captured before the counter update.
- frameDone asserts for the cycle after the edge that registers the vsync rise. frameCount updates on that same edge.
- vsync fall and href rise on the same cycle: FRAME is entered and the byte in dataQ on that cycle is ignored. The OV7670 guarantees href low for at least 10 pclk after vsync falls.

## Test plan
- **Mini frame.** H_ACTIVE=4, V_ACTIVE=2; captureEn=1; vsync pulse; 2 lines of 8 bytes, starting F8,00 then 07,E0. Expect:
  - 8 strobes;
  - the first two writes are (0,0)=0xF800 and (1,0)=0x07E0;
  - the last write is at (3,1);
  - frameDone pulses once and frameCount=1.
- **Clipping.** H_ACTIVE=4, lines of 6 pixels; V_ACTIVE=2 with 3 lines. Expect only 8 strobes, outX never exceeding 3, outY never exceeding 1.
- **Odd byte count.** Line 0 has 7 bytes. Expect:
  - 3 strobes on line 0;
  - lineErr=1 and it stays 1;
  - line 1 starts at (0,1) with the correct byte pairing.
- **Startup mid-frame.** Assert captureEn while vsync=0 and href is toggling. Expect no strobes until a vsync rise-then-fall has been seen; the first write is at (0,0).
- **Stop mid-frame.** Drop captureEn halfway through a frame. Expect:
  - that frame completes and frameDone pulses;
  - the state returns to IDLE;
  - the next frame produces 0 strobes.
- **Reset and wrap.** Assert reset mid-line: all outputs read 0 in the same cycle (asynchronous reset). Then run 256 frames: frameCount wraps to 0 and 256 frameDone pulses are observed.
